// File: rtl/mig_app_master.sv
// mig_app_master: drives the MIG 7-series app interface from a simple
// valid/ready request stream (one BL8 burst per request) and buffers read
// returns in a credit-protected FWFT FIFO, since MIG cannot be stalled on
// app_rd_data_valid.
module mig_app_master #(
  parameter int ADDR_WIDTH    = 29,
  parameter int DATA_WIDTH    = 256,
  parameter int MASK_WIDTH    = 32,
  parameter int RD_FIFO_DEPTH = 8
) (
  input  logic                  ui_clk,
  input  logic                  wire_rst_n,
  input  logic                  init_calib_complete,
  // request stream
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [MASK_WIDTH-1:0] req_wmask,
  // read response stream
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  err,
  // MIG command channel
  output logic                  app_en,
  output logic [2:0]            app_cmd,
  output logic [ADDR_WIDTH-1:0] app_addr,
  input  logic                  app_rdy,
  // MIG write-data channel
  output logic                  app_wdf_wren,
  output logic                  app_wdf_end,
  output logic [DATA_WIDTH-1:0] app_wdf_data,
  output logic [MASK_WIDTH-1:0] app_wdf_mask,
  input  logic                  app_wdf_rdy,
  // MIG read-return channel
  input  logic [DATA_WIDTH-1:0] app_rd_data,
  input  logic                  app_rd_data_valid,
  input  logic                  app_rd_data_end
);

  localparam int PW = $clog2(RD_FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(RD_FIFO_DEPTH);
  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  state_t                state_q, state_d;
  logic                  app_en_q, app_en_d;
  logic [2:0]            app_cmd_q, app_cmd_d;
  logic [ADDR_WIDTH-1:0] app_addr_q, app_addr_d;
  logic                  app_wdf_wren_q, app_wdf_wren_d;
  logic [DATA_WIDTH-1:0] app_wdf_data_q, app_wdf_data_d;
  logic [MASK_WIDTH-1:0] app_wdf_mask_q, app_wdf_mask_d;
  logic                  cmd_done_q, cmd_done_d;
  logic                  dat_done_q, dat_done_d;
  logic                  rst_done_q, rst_done_d;
  logic [CW-1:0]         rd_cnt_q, rd_cnt_d;
  logic [CW-1:0]         fifo_cnt_q, fifo_cnt_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] mem_q [RD_FIFO_DEPTH];

  logic accept, cmd_fire, dat_fire, rd_issue;
  logic pop, push, fifo_full, rd_data_stray;

  // app_rd_data_end carries no information for BL8 in 4:1 mode and the low
  // address bits are forced to a burst boundary.
  logic unused_ok;
  assign unused_ok = &{1'b0, app_rd_data_end, req_addr[2:0]};

  // rst_done_q keeps req_ready low while reset is held and for the first
  // edge after release, so nothing is accepted out of a half-reset state.
  assign req_ready = rst_done_q && (state_q == IDLE) && init_calib_complete &&
                     (req_wr || (rd_cnt_q < DEPTH_C));
  assign accept    = req_valid && req_ready;
  assign cmd_fire  = app_en_q && app_rdy;
  assign dat_fire  = app_wdf_wren_q && app_wdf_rdy;

  assign rsp_valid     = (fifo_cnt_q != '0);
  assign rsp_rdata     = mem_q[rd_ptr_q];
  assign fifo_full     = (fifo_cnt_q == DEPTH_C);
  assign pop           = rsp_valid && rsp_ready;
  // Data with no outstanding read is flagged and dropped so the credit
  // counter can never be driven below zero by its pop.
  assign rd_data_stray = app_rd_data_valid && (rd_cnt_q == '0);
  assign push          = app_rd_data_valid && !rd_data_stray && (!fifo_full || pop);

  assign app_en       = app_en_q;
  assign app_cmd      = app_cmd_q;
  assign app_addr     = app_addr_q;
  assign app_wdf_wren = app_wdf_wren_q;
  assign app_wdf_end  = app_wdf_wren_q;
  assign app_wdf_data = app_wdf_data_q;
  assign app_wdf_mask = app_wdf_mask_q;
  assign err          = err_q;

  // Request FSM: latches the request and runs the command / write-data
  // handshakes; the two write halves retire independently.
  always_comb begin
    state_d        = state_q;
    app_en_d       = app_en_q;
    app_cmd_d      = app_cmd_q;
    app_addr_d     = app_addr_q;
    app_wdf_wren_d = app_wdf_wren_q;
    app_wdf_data_d = app_wdf_data_q;
    app_wdf_mask_d = app_wdf_mask_q;
    cmd_done_d     = cmd_done_q;
    dat_done_d     = dat_done_q;
    rd_issue       = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          app_addr_d = {req_addr[ADDR_WIDTH-1:3], 3'b000};
          app_en_d   = 1'b1;
          if (req_wr) begin
            state_d        = WRITE;
            app_cmd_d      = CMD_WR;
            app_wdf_wren_d = 1'b1;
            app_wdf_data_d = req_wdata;
            app_wdf_mask_d = req_wmask;
            cmd_done_d     = 1'b0;
            dat_done_d     = 1'b0;
          end else begin
            state_d   = READ;
            app_cmd_d = CMD_RD;
          end
        end
      end
      WRITE: begin
        if (cmd_fire) begin
          app_en_d   = 1'b0;
          cmd_done_d = 1'b1;
        end
        if (dat_fire) begin
          app_wdf_wren_d = 1'b0;
          dat_done_d     = 1'b1;
        end
        if ((cmd_done_q || cmd_fire) && (dat_done_q || dat_fire))
          state_d = IDLE;
      end
      READ: begin
        if (app_rdy) begin
          app_en_d = 1'b0;
          rd_issue = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Read credits, FIFO pointers/occupancy and the sticky error flag.
  always_comb begin
    rd_cnt_d   = rd_cnt_q;
    fifo_cnt_d = fifo_cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    rst_done_d = 1'b1;
    case ({rd_issue, pop})
      2'b10:   rd_cnt_d = rd_cnt_q + 1'b1;
      2'b01:   rd_cnt_d = rd_cnt_q - 1'b1;
      default: rd_cnt_d = rd_cnt_q;
    endcase
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    err_d = err_q || rd_data_stray || (app_rd_data_valid && fifo_full && !pop);
  end

  // State and control registers; reset clears in-flight work immediately.
  always_ff @(posedge ui_clk or negedge wire_rst_n) begin
    if (!wire_rst_n) begin
      state_q        <= IDLE;
      app_en_q       <= 1'b0;
      app_cmd_q      <= '0;
      app_addr_q     <= '0;
      app_wdf_wren_q <= 1'b0;
      app_wdf_data_q <= '0;
      app_wdf_mask_q <= '0;
      cmd_done_q     <= 1'b0;
      dat_done_q     <= 1'b0;
      rst_done_q     <= 1'b0;
      rd_cnt_q       <= '0;
      fifo_cnt_q     <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      app_en_q       <= app_en_d;
      app_cmd_q      <= app_cmd_d;
      app_addr_q     <= app_addr_d;
      app_wdf_wren_q <= app_wdf_wren_d;
      app_wdf_data_q <= app_wdf_data_d;
      app_wdf_mask_q <= app_wdf_mask_d;
      cmd_done_q     <= cmd_done_d;
      dat_done_q     <= dat_done_d;
      rst_done_q     <= rst_done_d;
      rd_cnt_q       <= rd_cnt_d;
      fifo_cnt_q     <= fifo_cnt_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      err_q          <= err_d;
    end
  end

  // FIFO storage; contents are don't-care while the occupancy count is zero.
  always_ff @(posedge ui_clk) begin
    if (push) mem_q[wr_ptr_q] <= app_rd_data;
  end

endmodule

// File: tb/tb_mig_app_master.sv
// Directed bench for mig_app_master with a small MIG behavioural model that
// stores writes and returns read data three cycles after command accept.
`timescale 1ns/1ps
module tb_mig_app_master;
  localparam int AW = 29, DW = 256, MW = 32, DEPTH = 8;

  logic          ui_clk = 1'b0;
  logic          wire_rst_n = 1'b0;
  logic          init_calib_complete = 1'b0;
  logic          req_valid = 1'b0, req_ready, req_wr = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [MW-1:0] req_wmask = '0;
  logic          rsp_valid, rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          err;
  logic          app_en, app_rdy = 1'b1;
  logic [2:0]    app_cmd;
  logic [AW-1:0] app_addr;
  logic          app_wdf_wren, app_wdf_end, app_wdf_rdy = 1'b1;
  logic [DW-1:0] app_wdf_data;
  logic [MW-1:0] app_wdf_mask;
  logic [DW-1:0] app_rd_data;
  logic          app_rd_data_valid, app_rd_data_end;
  logic          mdl_valid = 1'b0, spur_valid = 1'b0;
  logic [DW-1:0] mdl_data = '0;

  assign app_rd_data_valid = mdl_valid | spur_valid;
  assign app_rd_data       = mdl_data;
  assign app_rd_data_end   = app_rd_data_valid;

  mig_app_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW), .RD_FIFO_DEPTH(DEPTH)) dut (
    .ui_clk(ui_clk), .wire_rst_n(wire_rst_n), .init_calib_complete(init_calib_complete),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .err(err),
    .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr), .app_rdy(app_rdy),
    .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_data(app_wdf_data),
    .app_wdf_mask(app_wdf_mask), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .app_rd_data_end(app_rd_data_end));

  always #5 ui_clk = ~ui_clk;

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return {8{32'(a) ^ 32'h5A5A_0000}};
  endfunction

  // Inputs change and outputs are checked just after the falling edge.
  task automatic nxt;
    @(negedge ui_clk);
    #1;
  endtask

  // MIG model: samples handshakes late in the low phase, well before the edge.
  typedef struct { int due; logic [DW-1:0] d; } ret_t;
  logic [DW-1:0] dram [logic [AW-1:0]];
  ret_t rq[$];
  int   mcyc = 0;
  initial forever begin
    ret_t r;
    @(negedge ui_clk);
    #3;
    mcyc++;
    mdl_valid = 1'b0;
    if (!wire_rst_n) rq.delete();
    else begin
      if (rq.size() > 0 && rq[0].due <= mcyc) begin
        r = rq.pop_front();
        mdl_valid = 1'b1;
        mdl_data  = r.d;
      end
      if (app_en && app_rdy) begin
        if (app_cmd == 3'b000) dram[app_addr] = app_wdf_data;
        else begin
          r.due = mcyc + 3;
          r.d   = dram.exists(app_addr) ? dram[app_addr] : pat(app_addr);
          rq.push_back(r);
        end
      end
    end
  end

  // Present a request, wait (bounded) for req_ready, let the accept edge pass.
  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d, input string tag);
    int n = 0;
    req_valid = 1'b1; req_wr = wr; req_addr = a; req_wdata = d; req_wmask = '0;
    #1;
    while (!req_ready && n < 40) begin nxt(); n++; end
    chk(tag, DW'(n < 40), DW'(1));
    nxt();
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag);
    int n = 0;
    while (!rsp_valid && n < 20) begin nxt(); n++; end
    chk(tag, DW'(n < 20), DW'(1));
  endtask

  localparam logic [DW-1:0] DA5 = {32{8'hA5}};
  localparam logic [DW-1:0] D1  = {8{32'hDEAD_BEEF}};
  localparam logic [DW-1:0] DC3 = {32{8'hC3}};

  initial begin
    // reset with calibration already high: nothing may be offered
    init_calib_complete = 1'b1;
    req_valid = 1'b1; req_wr = 1'b1;
    repeat (2) nxt();
    chk("rst_req_ready", DW'(req_ready), DW'(0));
    chk("rst_app_en", DW'(app_en), DW'(0));
    chk("rst_wren", DW'(app_wdf_wren), DW'(0));
    chk("rst_wdf_end", DW'(app_wdf_end), DW'(0));
    chk("rst_rsp_valid", DW'(rsp_valid), DW'(0));
    chk("rst_err", DW'(err), DW'(0));
    chk("rst_addr", DW'(app_addr), DW'(0));
    chk("rst_cmd", DW'(app_cmd), DW'(0));
    chk("rst_wdata", app_wdf_data, '0);
    chk("rst_wmask", DW'(app_wdf_mask), DW'(0));

    // calibration gate, then write with command channel stalled 3 cycles
    wire_rst_n = 1'b1; init_calib_complete = 1'b0;
    req_addr = 29'h13; req_wdata = DA5; req_wmask = '0;
    app_rdy = 1'b0; app_wdf_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      nxt();
      chk("cal_req_ready", DW'(req_ready), DW'(0));
      chk("cal_app_en", DW'(app_en), DW'(0));
    end
    init_calib_complete = 1'b1;
    #1;
    chk("cal_accept", DW'(req_ready), DW'(1));
    nxt();
    req_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      app_rdy = (i == 4);
      chk("w1_en", DW'(app_en), DW'(1));
      chk("w1_wren", DW'(app_wdf_wren), DW'(i == 1));
      chk("w1_end", DW'(app_wdf_end), DW'(i == 1));
      chk("w1_addr", DW'(app_addr), DW'(29'h10));
      chk("w1_cmd", DW'(app_cmd), DW'(0));
      if (i == 1) begin
        chk("w1_data", app_wdf_data, DA5);
        chk("w1_mask", DW'(app_wdf_mask), DW'(0));
      end
      nxt();
    end
    chk("w1_en_drop", DW'(app_en), DW'(0));
    chk("w1_idle", DW'(req_ready), DW'(1));

    // opposite skew: data channel stalled 3 cycles
    app_rdy = 1'b1; app_wdf_rdy = 1'b0;
    issue(1'b1, 29'h40, D1, "w2_accept");
    for (int i = 1; i <= 4; i++) begin
      app_wdf_rdy = (i == 4);
      chk("w2_en", DW'(app_en), DW'(i == 1));
      chk("w2_wren", DW'(app_wdf_wren), DW'(1));
      chk("w2_data", app_wdf_data, D1);
      chk("w2_addr", DW'(app_addr), DW'(29'h40));
      nxt();
    end
    chk("w2_wren_drop", DW'(app_wdf_wren), DW'(0));
    chk("w2_idle", DW'(req_ready), DW'(1));

    // both halves in the same cycle: two cycles per request
    app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    issue(1'b1, 29'h80, DC3, "w3_accept");
    chk("w3_en", DW'(app_en), DW'(1));
    chk("w3_wren", DW'(app_wdf_wren), DW'(1));
    nxt();
    chk("w3_en_drop", DW'(app_en), DW'(0));
    chk("w3_wren_drop", DW'(app_wdf_wren), DW'(0));
    chk("w3_idle", DW'(req_ready), DW'(1));

    // read back the data written to 0x40
    rsp_ready = 1'b1;
    issue(1'b0, 29'h47, '0, "rt_accept");
    chk("rt_en", DW'(app_en), DW'(1));
    chk("rt_cmd", DW'(app_cmd), DW'(1));
    chk("rt_addr", DW'(app_addr), DW'(29'h40));
    nxt();
    chk("rt_en_drop", DW'(app_en), DW'(0));
    wait_rsp("rt_wait");
    chk("rt_data", rsp_rdata, D1);
    nxt();
    chk("rt_one_beat", DW'(rsp_valid), DW'(0));

    // credit limit: eight reads fill the FIFO, the ninth waits for a pop
    rsp_ready = 1'b0;
    for (int i = 0; i < 8; i++) issue(1'b0, AW'(32'h100 + i * 8), '0, "cr_accept");
    repeat (8) nxt();
    chk("cr_full_valid", DW'(rsp_valid), DW'(1));
    chk("cr_head", rsp_rdata, pat(29'h100));
    chk("cr_err", DW'(err), DW'(0));
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 29'h140;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("cr_stall", DW'(req_ready), DW'(0));
      nxt();
    end
    rsp_ready = 1'b1;
    nxt();
    rsp_ready = 1'b0;
    #1;
    chk("cr_release", DW'(req_ready), DW'(1));
    nxt();
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      wait_rsp("cr_wait");
      chk("cr_order", rsp_rdata, pat(AW'(32'h100 + k * 8)));
      nxt();
    end
    chk("cr_drained", DW'(rsp_valid), DW'(0));
    chk("cr_err_end", DW'(err), DW'(0));

    // stray read data with nothing outstanding
    spur_valid = 1'b1;
    nxt();
    spur_valid = 1'b0;
    chk("spur_err", DW'(err), DW'(1));
    repeat (3) nxt();
    chk("spur_sticky", DW'(err), DW'(1));

    // reset while a read command is held and a response sits in the FIFO
    rsp_ready = 1'b0;
    issue(1'b0, 29'h200, '0, "mr_accept0");
    wait_rsp("mr_wait");
    app_rdy = 1'b0;
    issue(1'b0, 29'h208, '0, "mr_accept1");
    chk("mr_en_hi", DW'(app_en), DW'(1));
    nxt();
    chk("mr_en_held", DW'(app_en), DW'(1));
    wire_rst_n = 1'b0;
    #1;
    chk("mr_en", DW'(app_en), DW'(0));
    chk("mr_cmd", DW'(app_cmd), DW'(0));
    chk("mr_addr", DW'(app_addr), DW'(0));
    chk("mr_wdata", app_wdf_data, '0);
    chk("mr_rsp_valid", DW'(rsp_valid), DW'(0));
    chk("mr_err", DW'(err), DW'(0));
    chk("mr_req_ready", DW'(req_ready), DW'(0));
    nxt();
    wire_rst_n = 1'b1; app_rdy = 1'b1;
    repeat (2) nxt();
    chk("mr_fifo_empty", DW'(rsp_valid), DW'(0));
    chk("mr_idle", DW'(req_ready), DW'(1));
    chk("mr_en_after", DW'(app_en), DW'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
